data_mem_ctrl: RTL and testbench
================================

Name: data_mem_ctrl

Overview:
Parametrised data memory with a valid/ready request port and a registered response, replacing the fixed 512-byte combinational-read data memory in the core's MEM stage. Supports byte, halfword and word loads and stores, with sign or zero extension and selectable byte order. Checks each access against the memory bounds and the access alignment. Storage is word-organised: DEPTH_WORDS x 32 bits with per-byte write lanes, so it maps to block RAM.

Parameters:
DEPTH_WORDS, 128, number of 32-bit words; byte capacity is DEPTH_WORDS*4 (512 bytes by default).
ADDR_W, 32, width of the byte address.
BIG_ENDIAN, 1, 1 = byte at lowest address is most significant; 0 = little-endian.

Ports:
CLK  input  1  clock, all state on rising edge
RST  input  1  synchronous active-high reset
req_valid  input  1  request present
req_ready  output  1  controller can accept a request this cycle
req_we  input  1  1 = store, 0 = load
req_size  input  2  00 byte, 01 half, 10 word; 11 is illegal and returns an error
req_unsigned  input  1  load zero-extends when 1, sign-extends when 0
req_addr  input  ADDR_W  byte address
req_wdata  input  32  store data, right-justified (byte in [7:0], half in [15:0])
rsp_valid  output  1  one-cycle pulse, response available
rsp_rdata  output  32  extended load data; 0 for stores and errors
rsp_err  output  1  qualified by rsp_valid; out-of-range, illegal size or disallowed misalignment

Behaviour:
- Reset values: req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, FSM=IDLE. Memory contents are not reset.
- One request outstanding at a time. A request is accepted on an edge where req_valid && req_ready. There is no response backpressure.
- FSM states:
  - IDLE: req_ready=1.
    - Error or single-word access: go to RESP.
    - Word-crossing access (feature on): go to SPLIT.
  - SPLIT: req_ready=0; performs the second word access; go to RESP.
  - RESP: rsp_valid=1, req_ready=0; go to IDLE.
- Latency from the acceptance edge to rsp_valid high:
  - Single-word access: 2 cycles, i.e. a throughput of one request per 2 cycles.
  - Split access: 3 cycles.
- rsp_rdata and rsp_err hold their values after the pulse until the next response.
- Size in bytes: n = 1, 2 or 4.
  - Out of range: addr + n - 1 >= DEPTH_WORDS*4, evaluated without overflow in ADDR_W+1 bits.
  - Misaligned: addr mod n != 0.
  - Crossing: addr[1:0] + n > 4.
- Error responses (out-of-range, illegal size, or disallowed misalignment): memory unchanged, rsp_err=1, rsp_rdata=0. Out-of-range takes priority over misalignment.
- Stores: byte lanes are written on the acceptance edge. Lane mapping follows BIG_ENDIAN: with BIG_ENDIAN=1, the value's MSB goes to the lowest address.
- Loads: the word is read on the acceptance edge. Lanes are extracted and assembled into an n-byte value, then extended per req_unsigned; word loads ignore req_unsigned.
- Store immediately followed by a load of the same address returns the new data, since the write edge precedes the read edge.
- RST asserted in SPLIT or RESP:
  - FSM returns to IDLE and no response is issued.
  - For a split store, the first word's lanes stay committed and the second word's lanes are dropped.

Optional Feature:
MISALIGNED_ACCESS_EN
- Defined:
  - Misaligned accesses within one word complete in the normal 2 cycles.
  - Crossing accesses use SPLIT:
    - Lower-address word on the acceptance edge.
    - Upper word (word index + 1) on the next edge.
  - A crossing that reaches past the last word is caught by the out-of-range check.
- Undefined: every misaligned access is an error response with no write. SPLIT is not synthesised.

Test Plan:
- BIG_ENDIAN=1:
  - Store word 0x11223344 @0x10.
  - Byte load signed @0x11 -> rsp_rdata=0x00000022, rsp_err=0, rsp_valid 2 cycles after acceptance.
  - Word load @0x10 -> 0x11223344.
- Store half 0x80FF @0x14:
  - Signed half load -> 0xFFFF80FF.
  - Unsigned half load -> 0x000080FF.
  - Byte load @0x15 unsigned -> 0x000000FF.
- Load word @0x200 (DEPTH_WORDS=128) -> rsp_err=1, rsp_rdata=0. Store to @0x1FE with size word -> rsp_err=1 and memory @0x1FC unchanged.
- Word load @0x12 after the first test's store, with @0x14 still holding 0x80FF:
  - Macro undefined -> rsp_err=1.
  - Macro defined -> rsp_err=0, rsp_rdata=0x334480FF, rsp_valid 3 cycles after acceptance, req_ready low for 2 cycles.
- Macro defined: word store 0xAABBCCDD @0x1E, with RST pulsed in the SPLIT cycle:
  - Bytes 0x1E/0x1F read 0xAA/0xBB.
  - 0x20/0x21 keep their prior values.
  - No rsp_valid; req_ready=1 in the cycle after reset.
- BIG_ENDIAN=0: store word 0x11223344 @0x0, then byte load @0x0 -> 0x00000044.

Source files
------------

// File: rtl/data_mem_ctrl.sv
// Word-organised data memory controller: valid/ready request port, registered response,
// byte/half/word loads and stores. Define MISALIGNED_ACCESS_EN to allow misaligned accesses.
module data_mem_ctrl #(
    parameter int unsigned DEPTH_WORDS = 128,
    parameter int unsigned ADDR_W      = 32,
    parameter bit          BIG_ENDIAN  = 1'b1
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err
);

    localparam int unsigned IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [ADDR_W:0] BYTES = (ADDR_W + 1)'(DEPTH_WORDS * 4);

    typedef enum logic [1:0] {StIdle, StSplit, StResp} state_e;

    state_e state_q, state_d;
    logic             we_q, we_d;
    logic [2:0]       n_q, n_d;
    logic             uns_q, uns_d;
    logic [1:0]       off_q, off_d;
    logic             err_q, err_d;
    logic             split_q, split_d;
    logic [IDX_W-1:0] hi_idx_q, hi_idx_d;
    logic [31:0]      wdata_hi_q, wdata_hi_d;
    logic [3:0]       be_hi_q, be_hi_d;
    logic [31:0]      rd_lo_q, rd_lo_d;
    logic [31:0]      rsp_rdata_q, rsp_rdata_d;
    logic             rsp_err_q, rsp_err_d;

    logic [31:0] mem_q [DEPTH_WORDS];
    logic [31:0] mem_rd_q;

    logic [2:0]       n_bytes;
    logic             size_ok, oob, req_err, req_split, accept, in_split;
    logic [ADDR_W:0]  end_addr;
    logic [IDX_W-1:0] req_idx;
    logic [7:0]       st_b [8];
    logic [7:0]       st_en;
    logic [31:0]      wdata_lo, wdata_hi;
    logic [3:0]       be_lo, be_hi;
    logic             mem_en, mem_we;
    logic [IDX_W-1:0] mem_idx;
    logic [3:0]       mem_be;
    logic [31:0]      mem_wdata;
    logic [7:0]       rb [8];
    logic [31:0]      lo_word, hi_word, ld_raw, load_val;

    // Address-order position of a byte lane within a word.
    function automatic int lane_pos(input int lane);
        return BIG_ENDIAN ? 3 - lane : lane;
    endfunction

    assign req_ready = (state_q == StIdle);
    assign accept    = req_valid && req_ready && !RST;
    assign in_split  = (state_q == StSplit) && !RST;
    assign req_idx   = req_addr[IDX_W+1:2];

    always_comb begin
        n_bytes = 3'd4;
        size_ok = 1'b1;
        case (req_size)
            2'b00:   n_bytes = 3'd1;
            2'b01:   n_bytes = 3'd2;
            2'b10:   n_bytes = 3'd4;
            default: size_ok = 1'b0;
        endcase
    end

    // Range check in ADDR_W+1 bits so the top of the address space cannot wrap.
    assign end_addr = {1'b0, req_addr} + {{(ADDR_W - 2){1'b0}}, n_bytes} - (ADDR_W + 1)'(1);
    assign oob      = end_addr >= BYTES;

`ifdef MISALIGNED_ACCESS_EN
    logic cross;
    assign cross     = ({1'b0, req_addr[1:0]} + n_bytes) > 3'd4;
    assign req_err   = !size_ok || oob;
    assign req_split = cross && !req_err;
`else
    logic misal;
    assign misal     = ((n_bytes == 3'd2) && req_addr[0]) ||
                       ((n_bytes == 3'd4) && (req_addr[1:0] != 2'b00));
    assign req_err   = !size_ok || oob || misal;
    assign req_split = 1'b0;
`endif

    // Spread the store value over an 8-byte window spanning the addressed word and the next.
    always_comb begin
        for (int p = 0; p < 8; p++) begin
            st_b[p]  = 8'h00;
            st_en[p] = 1'b0;
        end
        for (int k = 0; k < 4; k++) begin
            if (k < int'(n_bytes)) begin
                st_en[int'(req_addr[1:0]) + k] = 1'b1;
                st_b[int'(req_addr[1:0]) + k]  = BIG_ENDIAN ?
                    req_wdata[8*(int'(n_bytes) - 1 - k) +: 8] : req_wdata[8*k +: 8];
            end
        end
        for (int l = 0; l < 4; l++) begin
            wdata_lo[8*l +: 8] = st_b[lane_pos(l)];
            wdata_hi[8*l +: 8] = st_b[lane_pos(l) + 4];
            be_lo[l]           = st_en[lane_pos(l)];
            be_hi[l]           = st_en[lane_pos(l) + 4];
        end
    end

    // Single memory port: request word on the acceptance edge, upper word in SPLIT.
    assign mem_en    = (accept && !req_err) || in_split;
    assign mem_idx   = in_split ? hi_idx_q : req_idx;
    assign mem_we    = in_split ? we_q : req_we;
    assign mem_be    = in_split ? be_hi_q : be_lo;
    assign mem_wdata = in_split ? wdata_hi_q : wdata_lo;

    always_ff @(posedge CLK) begin
        if (mem_en) begin
            if (mem_we) begin
                for (int l = 0; l < 4; l++) begin
                    if (mem_be[l]) begin
                        mem_q[mem_idx][8*l +: 8] <= mem_wdata[8*l +: 8];
                    end
                end
            end
            mem_rd_q <= mem_q[mem_idx];
        end
    end

    assign lo_word = split_q ? rd_lo_q : mem_rd_q;
    assign hi_word = mem_rd_q;

    always_comb begin
        for (int p = 0; p < 8; p++) begin
            rb[p] = 8'h00;
        end
        for (int l = 0; l < 4; l++) begin
            rb[lane_pos(l)]     = lo_word[8*l +: 8];
            rb[lane_pos(l) + 4] = hi_word[8*l +: 8];
        end
        ld_raw = 32'h0;
        for (int k = 0; k < 4; k++) begin
            if (k < int'(n_q)) begin
                if (BIG_ENDIAN) begin
                    ld_raw[8*(int'(n_q) - 1 - k) +: 8] = rb[int'(off_q) + k];
                end else begin
                    ld_raw[8*k +: 8] = rb[int'(off_q) + k];
                end
            end
        end
        case (n_q)
            3'd1:    load_val = uns_q ? {24'h0, ld_raw[7:0]} : {{24{ld_raw[7]}}, ld_raw[7:0]};
            3'd2:    load_val = uns_q ? {16'h0, ld_raw[15:0]} : {{16{ld_raw[15]}}, ld_raw[15:0]};
            default: load_val = ld_raw;
        endcase
        if (err_q || we_q) begin
            load_val = 32'h0;
        end
    end

    always_comb begin
        state_d     = state_q;
        we_d        = we_q;
        n_d         = n_q;
        uns_d       = uns_q;
        off_d       = off_q;
        err_d       = err_q;
        split_d     = split_q;
        hi_idx_d    = hi_idx_q;
        wdata_hi_d  = wdata_hi_q;
        be_hi_d     = be_hi_q;
        rd_lo_d     = rd_lo_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    we_d       = req_we;
                    n_d        = n_bytes;
                    uns_d      = req_unsigned;
                    off_d      = req_addr[1:0];
                    err_d      = req_err;
                    split_d    = req_split;
                    hi_idx_d   = req_idx + IDX_W'(1);
                    wdata_hi_d = wdata_hi;
                    be_hi_d    = be_hi;
                    state_d    = req_split ? StSplit : StResp;
                end
            end
            StSplit: begin
                rd_lo_d = mem_rd_q;
                state_d = StResp;
            end
            StResp: begin
                rsp_rdata_d = load_val;
                rsp_err_d   = err_q;
                state_d     = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= StIdle;
            we_q        <= 1'b0;
            n_q         <= 3'd4;
            uns_q       <= 1'b0;
            off_q       <= 2'b00;
            err_q       <= 1'b0;
            split_q     <= 1'b0;
            hi_idx_q    <= '0;
            wdata_hi_q  <= 32'h0;
            be_hi_q     <= 4'h0;
            rd_lo_q     <= 32'h0;
            rsp_rdata_q <= 32'h0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            we_q        <= we_d;
            n_q         <= n_d;
            uns_q       <= uns_d;
            off_q       <= off_d;
            err_q       <= err_d;
            split_q     <= split_d;
            hi_idx_q    <= hi_idx_d;
            wdata_hi_q  <= wdata_hi_d;
            be_hi_q     <= be_hi_d;
            rd_lo_q     <= rd_lo_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    // A response cut short by reset is never presented.
    assign rsp_valid = (state_q == StResp) && !RST;
    assign rsp_rdata = rsp_valid ? load_val : rsp_rdata_q;
    assign rsp_err   = rsp_valid ? err_q : rsp_err_q;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed bench for data_mem_ctrl: big-endian and little-endian instances, scoreboard of
// expected responses. Honours MISALIGNED_ACCESS_EN to pick the expected misaligned behaviour.
module tb_data_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        v_be, v_le;
    logic        we, uns;
    logic [1:0]  size;
    logic [31:0] addr, wdata;

    logic        ready_be, valid_be, err_be;
    logic [31:0] rdata_be;
    logic        ready_le, valid_le, err_le;
    logic [31:0] rdata_le;

    logic        sel_le;
    logic        o_ready, o_valid, o_err;
    logic [31:0] o_rdata;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
    } exp_t;
    exp_t sb_q[$];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    data_mem_ctrl #(.DEPTH_WORDS(128), .ADDR_W(32), .BIG_ENDIAN(1'b1)) dut (
        .CLK(clk), .RST(rst), .req_valid(v_be), .req_ready(ready_be), .req_we(we),
        .req_size(size), .req_unsigned(uns), .req_addr(addr), .req_wdata(wdata),
        .rsp_valid(valid_be), .rsp_rdata(rdata_be), .rsp_err(err_be)
    );

    data_mem_ctrl #(.DEPTH_WORDS(128), .ADDR_W(32), .BIG_ENDIAN(1'b0)) dut_le (
        .CLK(clk), .RST(rst), .req_valid(v_le), .req_ready(ready_le), .req_we(we),
        .req_size(size), .req_unsigned(uns), .req_addr(addr), .req_wdata(wdata),
        .rsp_valid(valid_le), .rsp_rdata(rdata_le), .rsp_err(err_le)
    );

    always_comb begin
        o_ready = sel_le ? ready_le : ready_be;
        o_valid = sel_le ? valid_le : valid_be;
        o_err   = sel_le ? err_le : err_be;
        o_rdata = sel_le ? rdata_le : rdata_be;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // One request; the expected response is queued up front and popped when rsp_valid fires.
    task automatic do_req(input string tag, input logic le, input logic w, input logic [1:0] sz,
                          input logic u, input logic [31:0] a, input logic [31:0] d,
                          input logic e_err, input logic [31:0] e_rd, input int e_lat);
        exp_t e;
        int   cyc;
        int   rlow;
        bit   seen;
        e.err   = e_err;
        e.rdata = e_rd;
        sb_q.push_back(e);
        @(negedge clk);
        sel_le = le;
        we = w; size = sz; uns = u; addr = a; wdata = d;
        if (le) v_le = 1'b1;
        else    v_be = 1'b1;
        check({tag, " ready"}, 32'(o_ready), 32'd1);
        @(posedge clk);
        #1;
        v_be = 1'b0;
        v_le = 1'b0;
        cyc  = 2;
        rlow = 0;
        seen = 1'b0;
        for (int i = 0; i < 8 && !seen; i++) begin
            if (!o_ready) rlow++;
            if (o_valid) begin
                seen = 1'b1;
            end else begin
                @(posedge clk);
                #1;
                cyc++;
            end
        end
        check({tag, " rsp seen"}, 32'(seen), 32'd1);
        e = sb_q.pop_front();
        if (seen) begin
            check({tag, " latency"}, 32'(cyc), 32'(e_lat));
            check({tag, " ready low"}, 32'(rlow), 32'(e_lat - 1));
            check({tag, " err"}, 32'(o_err), 32'(e.err));
            check({tag, " rdata"}, o_rdata, e.rdata);
            @(posedge clk);
            #1;
            check({tag, " pulse end"}, 32'(o_valid), 32'd0);
            check({tag, " rdata hold"}, o_rdata, e.rdata);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; v_be = 1'b0; v_le = 1'b0; sel_le = 1'b0;
        we = 1'b0; size = 2'b00; uns = 1'b0; addr = 32'h0; wdata = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("reset ready", 32'(ready_be), 32'd1);
        check("reset valid", 32'(valid_be), 32'd0);
        check("reset rdata", rdata_be, 32'h0);
        check("reset err", 32'(err_be), 32'd0);

        do_req("st w 0x10", 0, 1, 2'b10, 0, 32'h10, 32'h11223344, 0, 32'h0, 2);
        do_req("ld b 0x11", 0, 0, 2'b00, 0, 32'h11, 32'h0, 0, 32'h00000022, 2);
        do_req("ld w 0x10", 0, 0, 2'b10, 0, 32'h10, 32'h0, 0, 32'h11223344, 2);
        do_req("st h 0x14", 0, 1, 2'b01, 0, 32'h14, 32'h000080FF, 0, 32'h0, 2);
        do_req("ld hs 0x14", 0, 0, 2'b01, 0, 32'h14, 32'h0, 0, 32'hFFFF80FF, 2);
        do_req("ld hu 0x14", 0, 0, 2'b01, 1, 32'h14, 32'h0, 0, 32'h000080FF, 2);
        do_req("ld bu 0x15", 0, 0, 2'b00, 1, 32'h15, 32'h0, 0, 32'h000000FF, 2);
        do_req("ld bs 0x14", 0, 0, 2'b00, 0, 32'h14, 32'h0, 0, 32'hFFFFFF80, 2);

        do_req("st w 0x1FC", 0, 1, 2'b10, 0, 32'h1FC, 32'hCAFEF00D, 0, 32'h0, 2);
        do_req("ld w 0x200", 0, 0, 2'b10, 0, 32'h200, 32'h0, 1, 32'h0, 2);
        do_req("st w 0x1FE", 0, 1, 2'b10, 0, 32'h1FE, 32'h12345678, 1, 32'h0, 2);
        do_req("ld w 0x1FC", 0, 0, 2'b10, 0, 32'h1FC, 32'h0, 0, 32'hCAFEF00D, 2);
        do_req("ld h 0x1FF", 0, 0, 2'b01, 0, 32'h1FF, 32'h0, 1, 32'h0, 2);
        do_req("ld bu 0x1FF", 0, 0, 2'b00, 1, 32'h1FF, 32'h0, 0, 32'h0000000D, 2);
        do_req("ld size11", 0, 0, 2'b11, 0, 32'h10, 32'h0, 1, 32'h0, 2);

`ifdef MISALIGNED_ACCESS_EN
        do_req("ld w 0x12 split", 0, 0, 2'b10, 0, 32'h12, 32'h0, 0, 32'h334480FF, 3);
        do_req("ld h 0x11 misal", 0, 0, 2'b01, 0, 32'h11, 32'h0, 0, 32'h00002233, 2);
        do_req("st h 0x11 misal", 0, 1, 2'b01, 0, 32'h11, 32'h0000BEEF, 0, 32'h0, 2);
        do_req("ld w 0x10 after", 0, 0, 2'b10, 0, 32'h10, 32'h0, 0, 32'h11BEEF44, 2);

        do_req("st w 0x1C", 0, 1, 2'b10, 0, 32'h1C, 32'h01020304, 0, 32'h0, 2);
        do_req("st w 0x20", 0, 1, 2'b10, 0, 32'h20, 32'h05060708, 0, 32'h0, 2);
        @(negedge clk);
        sel_le = 1'b0;
        we = 1'b1; size = 2'b10; uns = 1'b0; addr = 32'h1E; wdata = 32'hAABBCCDD;
        v_be = 1'b1;
        @(posedge clk);
        #1;
        v_be = 1'b0;
        check("split rst in split", 32'(ready_be), 32'd0);
        rst = 1'b1;
        #1;
        check("split rst valid0", 32'(valid_be), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("split rst after valid", 32'(valid_be), 32'd0);
        check("split rst after ready", 32'(ready_be), 32'd1);
        @(posedge clk);
        #1;
        check("split rst no rsp", 32'(valid_be), 32'd0);
        do_req("ld bu 0x1E", 0, 0, 2'b00, 1, 32'h1E, 32'h0, 0, 32'h000000AA, 2);
        do_req("ld bu 0x1F", 0, 0, 2'b00, 1, 32'h1F, 32'h0, 0, 32'h000000BB, 2);
        do_req("ld bu 0x20", 0, 0, 2'b00, 1, 32'h20, 32'h0, 0, 32'h00000005, 2);
        do_req("ld bu 0x21", 0, 0, 2'b00, 1, 32'h21, 32'h0, 0, 32'h00000006, 2);
        do_req("ld w 0x1C", 0, 0, 2'b10, 0, 32'h1C, 32'h0, 0, 32'h0102AABB, 2);
`else
        do_req("ld w 0x12 misal", 0, 0, 2'b10, 0, 32'h12, 32'h0, 1, 32'h0, 2);
        do_req("ld h 0x11 misal", 0, 0, 2'b01, 0, 32'h11, 32'h0, 1, 32'h0, 2);
        do_req("st h 0x11 misal", 0, 1, 2'b01, 0, 32'h11, 32'h0000BEEF, 1, 32'h0, 2);
        do_req("ld w 0x10 after", 0, 0, 2'b10, 0, 32'h10, 32'h0, 0, 32'h11223344, 2);
`endif

        do_req("le st w 0x0", 1, 1, 2'b10, 0, 32'h0, 32'h11223344, 0, 32'h0, 2);
        do_req("le ld b 0x0", 1, 0, 2'b00, 0, 32'h0, 32'h0, 0, 32'h00000044, 2);
        do_req("le ld h 0x2", 1, 0, 2'b01, 0, 32'h2, 32'h0, 0, 32'h00001122, 2);
        do_req("le ld b 0x3", 1, 0, 2'b00, 1, 32'h3, 32'h0, 0, 32'h00000011, 2);

        check("scoreboard empty", 32'(sb_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
